// File: rtl/mod_instruction_fetch.sv
// Instruction fetch stage: owns the PC, drives the ROM address and registers
// fetched words into IF/ID. Optional accept counter under FETCH_PERF_CNT_EN.
module mod_instruction_fetch #(
  parameter int unsigned       ADDR_W   = 30,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] address,
  input  logic [31:0]       instruction,
  input  logic              mem_end,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              vld_q, vld_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] opc_q, opc_d;
  logic              accept;
  logic              slot_free;

  assign accept    = vld_q & out_ready;
  assign slot_free = ~vld_q | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    if (redirect_valid) begin
      // Flush drops whatever sits in IF/ID, accepted or not.
      pc_d    = redirect_addr;
      vld_d   = 1'b0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (mem_end) begin
        if (accept) vld_d = 1'b0;
        state_d = HALT;
      end else if (slot_free) begin
        instr_d = instruction;
        opc_d   = pc_q;
        vld_d   = 1'b1;
        pc_d    = pc_q + PC_ONE;
      end
    end else begin
      if (accept) vld_d = 1'b0;
    end
  end

  assign address   = pc_q;
  assign out_valid = vld_q;
  assign out_instr = instr_q;
  assign out_pc    = opc_q;
  assign halted    = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_q;

  // Saturating; only reset clears it, redirects leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign fetch_count = cnt_q;
`else
  assign fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_mod_instruction_fetch.sv
// Self-checking bench for mod_instruction_fetch: directed scenarios plus
// randomized ready/redirect traffic against a transaction-level scoreboard.
module tb_mod_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] address;
  logic [31:0] instruction;
  logic        mem_end;
  logic        redirect_valid = 1'b0;
  logic [29:0] redirect_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [29:0] out_pc;
  logic        halted;
  logic [31:0] fetch_count;

  logic        me_off = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [29:0] exp_head = '0;
  logic [31:0] acc_cnt = '0;

  always #5 clk = ~clk;

  mod_instruction_fetch #(.ADDR_W(30), .RESET_PC(30'd0)) dut (
    .clk(clk), .rst(rst), .address(address), .instruction(instruction),
    .mem_end(mem_end), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .halted(halted), .fetch_count(fetch_count)
  );

  function automatic logic [31:0] rom_word(input logic [29:0] a);
    case (a)
      30'd0:   return 32'h04000001;
      30'd2:   return 32'h04020003;
      30'd32:  return 32'h00400820;
      30'd34:  return 32'h0BFFFFFE;
      default: return ({2'b0, a} * 32'h9E3779B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  function automatic logic rom_end(input logic [29:0] a);
    return !me_off && (a > 30'd34);
  endfunction

  always_comb begin
    instruction = rom_word(address);
    mem_end     = rom_end(address);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // One clock: evaluate the outgoing item, step the edge, then check the
  // fetch rules against what was presented before the edge.
  task automatic cycle();
    logic        pv, prdy, pacc, predir, pme, phalt;
    logic [29:0] ppc, paddr, rdaddr, nxt;
    logic [31:0] pinstr;
    pv = out_valid; prdy = out_ready; pacc = out_valid && out_ready;
    predir = redirect_valid; rdaddr = redirect_addr;
    pme = mem_end; phalt = halted; ppc = out_pc; paddr = address; pinstr = out_instr;
    nxt = paddr + 30'd1;
    if (pv) begin
      chk("item_pc", {2'b0, out_pc}, {2'b0, exp_head});
      chk("item_instr", out_instr, rom_word(out_pc));
      chk("item_in_prog", {31'b0, rom_end(out_pc)}, 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    if (pacc) begin
      acc_cnt  = acc_cnt + 32'd1;
      exp_head = exp_head + 30'd1;
    end
    if (predir) begin
      exp_head = rdaddr;
      chk("redir_flush", {31'b0, out_valid}, 32'd0);
      chk("redir_pc", {2'b0, address}, {2'b0, rdaddr});
      chk("redir_run", {31'b0, halted}, 32'd0);
    end else if (phalt) begin
      chk("halt_hold_pc", {2'b0, address}, {2'b0, paddr});
      chk("halt_stays", {31'b0, halted}, 32'd1);
      chk("halt_valid", {31'b0, out_valid}, {31'b0, pv && !pacc});
    end else if (pme) begin
      chk("end_halts", {31'b0, halted}, 32'd1);
      chk("end_hold_pc", {2'b0, address}, {2'b0, paddr});
      chk("end_valid", {31'b0, out_valid}, {31'b0, pv && !pacc});
      if (pv && !pacc) chk("end_stable_pc", {2'b0, out_pc}, {2'b0, ppc});
    end else if (pv && !prdy) begin
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_pc", {2'b0, out_pc}, {2'b0, ppc});
      chk("stall_instr", out_instr, pinstr);
      chk("stall_addr", {2'b0, address}, {2'b0, paddr});
    end else begin
      chk("cap_valid", {31'b0, out_valid}, 32'd1);
      chk("cap_pc", {2'b0, out_pc}, {2'b0, paddr});
      chk("cap_next_addr", {2'b0, address}, {2'b0, nxt});
      chk("run_not_halted", {31'b0, halted}, 32'd0);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("count", fetch_count, acc_cnt);
`else
    chk("count_tied", fetch_count, 32'd0);
`endif
  endtask

  task automatic run_to_pc(input logic [29:0] target, input string tag);
    for (int i = 0; i < 60 && !(out_valid && out_pc == target); i++) cycle();
    chk(tag, {2'b0, out_pc}, {2'b0, target});
  endtask

  task automatic redirect(input logic [29:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_addr", {2'b0, address}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc", {2'b0, out_pc}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Free run to the end of program memory
    cycle();
    chk("first_valid", {31'b0, out_valid}, 32'd1);
    chk("first_instr", out_instr, 32'h04000001);
    for (int i = 0; i < 60 && !halted; i++) cycle();
    chk("halt_reached", {31'b0, halted}, 32'd1);
    chk("halt_addr", {2'b0, address}, 32'd35);
    chk("halt_drained", {31'b0, out_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("count_35", fetch_count, 32'd35);
`endif
    cycle();

    // Leave HALT by redirect
    redirect(30'd32);
    chk("unhalt", {31'b0, halted}, 32'd0);
    cycle();
    chk("resume_pc", {2'b0, out_pc}, 32'd32);
    chk("resume_instr", out_instr, 32'h00400820);

    // Stall
    redirect(30'd0);
    run_to_pc(30'd5, "reach_pc5");
    out_ready = 1'b0;
    repeat (3) cycle();
    chk("stall3_pc", {2'b0, out_pc}, 32'd5);
    chk("stall3_addr", {2'b0, address}, 32'd6);
    out_ready = 1'b1;
    cycle();
    chk("release_pc", {2'b0, out_pc}, 32'd6);

    // Flush while stalled
    run_to_pc(30'd10, "reach_pc10");
    out_ready = 1'b0;
    redirect(30'd2);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    cycle();
    chk("flush_pc", {2'b0, out_pc}, 32'd2);
    chk("flush_instr", out_instr, 32'h04020003);

    // Redirect beats mem_end
    redirect(30'd40);
    redirect(30'd40);
    chk("redir_beats_end", {31'b0, halted}, 32'd0);
    cycle();
    chk("end_after", {31'b0, halted}, 32'd1);

    // PC wrap
    me_off = 1'b1;
    redirect(30'h3FFF_FFFF);
    chk("wrap_top", {2'b0, address}, 32'h3FFF_FFFF);
    cycle();
    chk("wrap_zero", {2'b0, address}, 32'd0);
    repeat (3) cycle();
    me_off = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_addr  = 30'($urandom_range(0, 40));
      cycle();
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    redirect(30'd20);
    repeat (5) cycle();

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_addr", {2'b0, address}, 32'd0);
    chk("arst_count", fetch_count, 32'd0);
    chk("arst_halted", {31'b0, halted}, 32'd0);
    exp_head = '0;
    acc_cnt  = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_instruction_fetch.md
Name: mod_instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction ROM.
- Owns the program counter (PC) and drives the ROM word address; the ROM returns `instruction` and `mem_end` combinationally in the same cycle.
- Registers each fetched word with its PC into the IF/ID register, which feeds decode through a valid/ready handshake.
- Supports stall, branch/jump redirect with flush, and halt at end of program memory.

Parameters:
- ADDR_W, 30: width of the PC and word address; byte address = {pc, 2'b00}.
- RESET_PC, 0: PC word address loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- address  output  ADDR_W  word address to the ROM; equals the current PC at all times.
- instruction  input  32  ROM read data for `address`, valid in the same cycle.
- mem_end  input  1  ROM flag; high when `address` is past the last program word.
- redirect_valid  input  1  one-cycle request to load a new PC (taken branch/jump).
- redirect_addr  input  ADDR_W  target word address for the redirect.
- out_valid  output  1  IF/ID register holds a valid instruction.
- out_ready  input  1  decode accepts the IF/ID contents this cycle.
- out_instr  output  32  registered instruction.
- out_pc  output  ADDR_W  word address `out_instr` was fetched from.
- halted  output  1  fetch has stopped at mem_end.
- fetch_count  output  32  accepted-instruction counter (see Optional Feature).

Behaviour:
- Reset (async, while rst=1):
  - pc=RESET_PC, state=RUN.
  - out_valid=0, out_instr=0, out_pc=0, halted=0, fetch_count=0.
- States:
  - RUN: fetching.
  - HALT: pc frozen, no captures, halted=1.
- Definitions used below:
  - accept = out_valid & out_ready.
  - slot_free = !out_valid | out_ready.
- Priority on each rising clk, highest first:
  1. redirect_valid=1 (any state):
     - pc<=redirect_addr, out_valid<=0 (flush, even if not accepted), state<=RUN, halted<=0.
     - The ROM word at the old pc is discarded.
  2. RUN & mem_end=1:
     - No capture; pc holds.
     - If accept, out_valid<=0; otherwise the IF/ID contents hold.
     - state<=HALT, halted<=1 from the next cycle.
  3. RUN & slot_free:
     - out_instr<=instruction, out_pc<=pc, out_valid<=1, pc<=pc+1.
  4. RUN & !slot_free (stall):
     - pc, out_instr, out_pc, out_valid hold unchanged.
  5. HALT:
     - pc holds; out_valid clears on accept.
     - Only a redirect or reset leaves HALT.
- Latency and throughput:
  - One instruction per cycle when out_ready stays high.
  - out_valid first rises one cycle after reset deasserts.
- Width rule: pc+1 is modulo 2^ADDR_W, so 2^ADDR_W-1 wraps to 0. No flag is raised; mem_end normally halts fetch before the wrap.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_instr and out_pc stay stable.
  - out_valid drops without an accept only on redirect or reset.
- Simultaneous events:
  - redirect and mem_end in the same cycle: redirect wins.
  - redirect and accept in the same cycle: the accept completes, out_valid<=0.
- Reset asserted mid-operation: the asynchronous reset overrides all state immediately, including any pending redirect.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - fetch_count increments by 1 on every accept.
  - Saturates at 32'hFFFF_FFFF.
  - Clears on reset only (not on redirect).
- Undefined: fetch_count is tied to 0 and no counter register is built. The port list is identical either way.

Test Plan:
- Free-run: reset, out_ready=1, ROM words 0..34, mem_end for address>34 -> captures in order:
  - out_pc 0 with out_instr 32'h04000001.
  - out_pc 32 with 32'h00400820.
  - out_pc 34 with 32'h0BFFFFFE.
  - Then halted=1, address frozen at 35, out_valid=0 after the last accept, fetch_count=35 (feature on).
- Stall: out_ready=0 for 3 cycles while out_valid=1 at out_pc=5 -> out_instr and out_pc stable, address stays 6; on release, out_pc=6 the next cycle.
- Redirect flush: redirect_valid=1 with redirect_addr=2 while out_valid=1 at out_pc=10 and out_ready=0 -> out_valid=0 the next cycle, then out_pc=2 with 32'h04020003.
- Redirect from HALT: after halting at 35, pulse redirect_addr=32 -> halted=0, state RUN, fetch resumes at out_pc=32.
- Priority and wrap:
  - redirect and mem_end in the same cycle -> no halt.
  - Force pc to 2^30-1 via redirect (ROM model mem_end=0) -> next address=0.
- Async reset: assert rst mid-stream between clock edges -> out_valid=0, address=RESET_PC immediately without waiting for a clock edge, fetch_count=0.
